eq_stream_sched: RTL and testbench

//  Sequencer for ILA-vs-HLS equivalence runs of the Gaussian-blur accelerator. Holds both designs in

---
 rtl/eq_pkg.sv | 30 +++
 rtl/eq_sync_fifo.sv | 63 ++++++
 rtl/eq_stream_sched.sv | 238 +++++++++++++++++++++++
 tb/tb_eq_stream_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// eq_pkg: shared types and defaults for the ILA-vs-HLS equivalence sequencer.
//   state_t  : sequencer states
//   CNT_W    : width of every run counter and of the mm_index/out_cnt outputs
//   DEF_*    : default parameter values used by eq_stream_sched
//   sat_inc  : saturating increment for CNT_W counters
package eq_pkg;

  localparam int CNT_W           = 16;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_IN_CNT      = 64;
  localparam int DEF_OUT_CNT     = 64;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_INIT_CYCLES = 2;
  localparam int DEF_MAX_CYCLES  = 4096;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    FAIL    = 3'd4,
    TIMEOUT = 3'd5
  } state_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/eq_sync_fifo.sv
// eq_sync_fifo: small synchronous FIFO buffering one design's output stream.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   clr        : synchronous flush, same effect as rst
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   dout       : head entry, valid whenever empty==0
//   full/empty : occupancy flags
// The head is read combinationally so the comparator can look at both
// heads and pop them in the same cycle without an extra read stage.
module eq_sync_fifo
  import eq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi))) mem_reg[gi] <= din;
      end
    end
  endgenerate

endmodule

// File: rtl/eq_stream_sched.sv
// eq_stream_sched: sequencer for ILA-vs-HLS equivalence runs.
//   Holds both designs in reset (dut_rst) for INIT_CYCLES after start, then
//   forks IN_CNT source tokens to both arg_1 inputs, buffers each design's
//   arg_0 output in its own FIFO and compares the two streams in order.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a run (honoured in IDLE and terminal states)
//   src_*                    source stream (ready only when both sides took it)
//   ila_in_* / hls_in_*      forked source stream to each design
//   ila_out_* / hls_out_*    each design's output stream
//   dut_rst                  reset to both designs (IDLE and INIT)
//   ila_en, hls_en           per-side clock enables
//   done, mismatch, timeout  sticky run status
//   mm_index                 compare index of the first mismatch
//   out_cnt                  number of output pairs compared
module eq_stream_sched
  import eq_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IN_CNT      = DEF_IN_CNT,
  parameter int OUT_CNT     = DEF_OUT_CNT,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] src_tdata,
  input  logic              src_tvalid,
  output logic              src_tready,
  output logic [DATA_W-1:0] ila_in_tdata,
  output logic              ila_in_tvalid,
  input  logic              ila_in_tready,
  output logic [DATA_W-1:0] hls_in_tdata,
  output logic              hls_in_tvalid,
  input  logic              hls_in_tready,
  input  logic [DATA_W-1:0] ila_out_tdata,
  input  logic              ila_out_tvalid,
  output logic              ila_out_tready,
  input  logic [DATA_W-1:0] hls_out_tdata,
  input  logic              hls_out_tvalid,
  output logic              hls_out_tready,
  output logic              dut_rst,
  output logic              ila_en,
  output logic              hls_en,
  output logic              done,
  output logic              mismatch,
  output logic              timeout,
  output logic [CNT_W-1:0]  mm_index,
  output logic [CNT_W-1:0]  out_cnt
);

  localparam logic [CNT_W-1:0] IN_LIM    = CNT_W'(IN_CNT);
  localparam logic [CNT_W-1:0] OUT_LIM   = CNT_W'(OUT_CNT);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_CYCLES - 1);

  state_t state_reg, state_next;

  logic [CNT_W-1:0] init_cnt_reg;
  logic [CNT_W-1:0] run_cnt_reg;
  logic [CNT_W-1:0] in_sent_reg;
  logic [CNT_W-1:0] out_cnt_reg;
  logic [CNT_W-1:0] mm_index_reg;
  logic             mismatch_reg;
  logic             done_reg;
  logic             timeout_reg;

  // Per-side signals, index 0 = ILA, index 1 = HLS.
  logic              in_tready_w     [2];
  logic              out_tvalid_w    [2];
  logic [DATA_W-1:0] out_tdata_w     [2];
  logic              side_in_tvalid  [2];
  logic              side_out_tready [2];
  logic              side_en         [2];
  logic              taken_reg       [2];
  logic [CNT_W-1:0]  recv_reg        [2];
  logic              fifo_push       [2];
  logic              fifo_full       [2];
  logic              fifo_empty      [2];
  logic [DATA_W-1:0] fifo_dout       [2];

  logic run;
  logic fork_active;
  logic src_hs;
  logic pop;
  logic clear_run;
  logic done_set;
  logic timeout_set;

  assign in_tready_w[0]  = ila_in_tready;
  assign in_tready_w[1]  = hls_in_tready;
  assign out_tvalid_w[0] = ila_out_tvalid;
  assign out_tvalid_w[1] = hls_out_tvalid;
  assign out_tdata_w[0]  = ila_out_tdata;
  assign out_tdata_w[1]  = hls_out_tdata;

  assign run         = (state_reg == RUN);
  assign fork_active = run && (in_sent_reg < IN_LIM);

  // A side that already took the current token no longer gates src_tready;
  // the source advances only once both sides hold their copy.
  assign src_tready = fork_active & src_tvalid &
                      (taken_reg[0] | in_tready_w[0]) &
                      (taken_reg[1] | in_tready_w[1]);
  assign src_hs     = src_tready;

  // Compare only when a full output pair is available.
  assign pop = run & ~fifo_empty[0] & ~fifo_empty[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      assign side_in_tvalid[gi]  = fork_active & src_tvalid & ~taken_reg[gi];
      assign side_out_tready[gi] = run & ~fifo_full[gi] & (recv_reg[gi] < OUT_LIM);
      assign fifo_push[gi]       = side_out_tready[gi] & out_tvalid_w[gi];
      assign side_en[gi]         = run & (recv_reg[gi] < OUT_LIM);

      always_ff @(posedge clk) begin
        if (rst || clear_run) begin
          taken_reg[gi] <= 1'b0;
          recv_reg[gi]  <= '0;
        end else begin
          if (src_hs) begin
            taken_reg[gi] <= 1'b0;
          end else if (side_in_tvalid[gi] && in_tready_w[gi]) begin
            taken_reg[gi] <= 1'b1;
          end
          if (fifo_push[gi]) recv_reg[gi] <= sat_inc(recv_reg[gi]);
        end
      end

      eq_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_run),
        .push  (fifo_push[gi]),
        .din   (out_tdata_w[gi]),
        .pop   (pop),
        .dout  (fifo_dout[gi]),
        .full  (fifo_full[gi]),
        .empty (fifo_empty[gi])
      );
    end
  endgenerate

  // Next-state logic. clear_run marks an accepted start: every counter,
  // flag and FIFO is wiped on the same edge that enters INIT.
  always_comb begin
    state_next  = state_reg;
    clear_run   = 1'b0;
    done_set    = 1'b0;
    timeout_set = 1'b0;
    case (state_reg)
      IDLE, DONE, FAIL, TIMEOUT: begin
        if (start) begin
          state_next = INIT;
          clear_run  = 1'b1;
        end
      end
      INIT: begin
        if (init_cnt_reg >= INIT_LAST) state_next = RUN;
      end
      RUN: begin
        if (mismatch_reg) begin
          state_next = FAIL;
        end else if ((out_cnt_reg == OUT_LIM) && fifo_empty[0] && fifo_empty[1]) begin
          state_next = DONE;
          done_set   = 1'b1;
        end else if (run_cnt_reg == RUN_LAST) begin
          state_next  = TIMEOUT;
          timeout_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      init_cnt_reg <= '0;
      run_cnt_reg  <= '0;
      in_sent_reg  <= '0;
      out_cnt_reg  <= '0;
      mm_index_reg <= '0;
      mismatch_reg <= 1'b0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (clear_run) begin
        init_cnt_reg <= '0;
        run_cnt_reg  <= '0;
        in_sent_reg  <= '0;
        out_cnt_reg  <= '0;
        mm_index_reg <= '0;
        mismatch_reg <= 1'b0;
        done_reg     <= 1'b0;
        timeout_reg  <= 1'b0;
      end else begin
        if (state_reg == INIT) init_cnt_reg <= sat_inc(init_cnt_reg);
        if (run)               run_cnt_reg  <= sat_inc(run_cnt_reg);
        if (src_hs)            in_sent_reg  <= sat_inc(in_sent_reg);
        if (pop) begin
          out_cnt_reg <= sat_inc(out_cnt_reg);
          // Only the first differing pair is recorded.
          if ((fifo_dout[0] != fifo_dout[1]) && !mismatch_reg) begin
            mismatch_reg <= 1'b1;
            mm_index_reg <= out_cnt_reg;
          end
        end
        if (done_set)    done_reg    <= 1'b1;
        if (timeout_set) timeout_reg <= 1'b1;
      end
    end
  end

  assign ila_in_tdata   = src_tdata;
  assign hls_in_tdata   = src_tdata;
  assign ila_in_tvalid  = side_in_tvalid[0];
  assign hls_in_tvalid  = side_in_tvalid[1];
  assign ila_out_tready = side_out_tready[0];
  assign hls_out_tready = side_out_tready[1];
  assign ila_en         = side_en[0];
  assign hls_en         = side_en[1];
  assign dut_rst        = (state_reg == IDLE) || (state_reg == INIT);
  assign done           = done_reg;
  assign mismatch       = mismatch_reg;
  assign timeout        = timeout_reg;
  assign mm_index       = mm_index_reg;
  assign out_cnt        = out_cnt_reg;

endmodule

// File: tb/tb_eq_stream_sched.sv
// tb_eq_stream_sched: directed-random bench for eq_stream_sched.
//   Two behavioural "designs" (ILA and HLS) map each input byte v to
//   v ^ 8'h58 in order; the HLS model can corrupt one index, stall its
//   output or emit slowly. Expected results come from these rules.
module tb_eq_stream_sched;

  localparam int DW    = 8;
  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int MAXC  = 64;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [DW-1:0] src_tdata;
  logic          src_tvalid, src_tready;
  logic [DW-1:0] ila_in_tdata, hls_in_tdata;
  logic          ila_in_tvalid, ila_in_tready, hls_in_tvalid, hls_in_tready;
  logic [DW-1:0] ila_out_tdata, hls_out_tdata;
  logic          ila_out_tvalid, ila_out_tready, hls_out_tvalid, hls_out_tready;
  logic          dut_rst, ila_en, hls_en, done, mismatch, timeout;
  logic [15:0]   mm_index, out_cnt;

  always #5 clk = ~clk;

  eq_stream_sched #(
    .DATA_W(DW), .IN_CNT(N), .OUT_CNT(N), .FIFO_DEPTH(DEPTH),
    .INIT_CYCLES(2), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tready(src_tready),
    .ila_in_tdata(ila_in_tdata), .ila_in_tvalid(ila_in_tvalid), .ila_in_tready(ila_in_tready),
    .hls_in_tdata(hls_in_tdata), .hls_in_tvalid(hls_in_tvalid), .hls_in_tready(hls_in_tready),
    .ila_out_tdata(ila_out_tdata), .ila_out_tvalid(ila_out_tvalid), .ila_out_tready(ila_out_tready),
    .hls_out_tdata(hls_out_tdata), .hls_out_tvalid(hls_out_tvalid), .hls_out_tready(hls_out_tready),
    .dut_rst(dut_rst), .ila_en(ila_en), .hls_en(hls_en),
    .done(done), .mismatch(mismatch), .timeout(timeout),
    .mm_index(mm_index), .out_cnt(out_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model state
  int         src_idx, ila_recv, hls_recv, hls_block, hls_mode, corrupt_idx, cyc;
  logic [7:0] ila_q[$], hls_q[$], ila_seen[$], hls_seen[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit seq_ok(input logic [7:0] q[$]);
    if (q.size() != N) return 1'b0;
    for (int i = 0; i < N; i++) if (q[i] != 8'(i)) return 1'b0;
    return 1'b1;
  endfunction

  // Index of the first output where the two reference streams differ.
  function automatic int exp_mm(input int cidx);
    for (int k = 0; k < N; k++) begin
      logic [7:0] a, b;
      a = 8'(k) ^ 8'h58;
      b = a ^ ((k == cidx) ? 8'h01 : 8'h00);
      if (a != b) return k;
    end
    return 0;
  endfunction

  // One clock: drive at negedge, record handshakes, advance models after posedge.
  task automatic cycle();
    logic s_hs, ii_hs, hi_hs, io_hs, ho_hs, rst_pre;
    logic [7:0] ii_d, hi_d, hv;
    src_tvalid    = (src_idx < N) && ((hls_block > 0) || ($urandom_range(0, 4) != 0));
    src_tdata     = 8'(src_idx);
    ila_in_tready = (hls_block > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    hls_in_tready = (hls_block > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
    ila_out_tvalid = ila_en && (ila_q.size() > 0) && ((hls_mode == 2) || ($urandom_range(0, 3) != 0));
    ila_out_tdata  = (ila_q.size() > 0) ? ila_q[0] : 8'h00;
    hls_out_tvalid = hls_en && (hls_q.size() > 0) &&
                     ((hls_mode == 0) ? ($urandom_range(0, 3) != 0) :
                      (hls_mode == 2) ? ((cyc % 4) == 0) : 1'b0);
    hls_out_tdata  = (hls_q.size() > 0) ? hls_q[0] : 8'h00;
    #1;
    if (hls_block > 0 && !dut_rst) check("src_tready_blocked", src_tready, 0);
    s_hs  = src_tvalid & src_tready;
    ii_hs = ila_in_tvalid & ila_in_tready;   ii_d = ila_in_tdata;
    hi_hs = hls_in_tvalid & hls_in_tready;   hi_d = hls_in_tdata;
    io_hs = ila_out_tvalid & ila_out_tready;
    ho_hs = hls_out_tvalid & hls_out_tready;
    rst_pre = dut_rst;
    @(posedge clk);
    cyc++;
    if (rst_pre) begin
      ila_q.delete(); hls_q.delete();
    end else begin
      if (ii_hs) begin ila_q.push_back(ii_d ^ 8'h58); ila_seen.push_back(ii_d); end
      if (hi_hs) begin
        hv = hi_d ^ 8'h58;
        if (hls_seen.size() == corrupt_idx) hv = hv ^ 8'h01;
        hls_q.push_back(hv); hls_seen.push_back(hi_d);
      end
      if (io_hs) begin void'(ila_q.pop_front()); ila_recv++; end
      if (ho_hs) begin void'(hls_q.pop_front()); hls_recv++; end
    end
    if (s_hs) src_idx++;
    if (hls_block > 0 && !rst_pre) hls_block--;
    @(negedge clk);
  endtask

  task automatic start_run(input string name);
    src_idx = 0; ila_recv = 0; hls_recv = 0; hls_block = 0;
    ila_q.delete(); hls_q.delete(); ila_seen.delete(); hls_seen.delete();
    start = 1'b1;
    cycle();
    start = 1'b0;
    check({name, "_init_rst0"}, dut_rst, 1);
    check({name, "_flags_clear"}, {done, mismatch, timeout}, 3'b000);
    cycle();
    check({name, "_init_rst1"}, dut_rst, 1);
    cycle();
    check({name, "_run_rst"}, dut_rst, 0);
    check({name, "_run_ila_en"}, ila_en, 1);
  endtask

  task automatic run_to_end(input string name);
    int k = 0;
    while (!(done || mismatch || timeout) && k < 400) begin
      cycle(); k++;
    end
    check({name, "_terminated"}, done | mismatch | timeout, 1);
  endtask

  task automatic check_good_run(input string name);
    check({name, "_done"}, done, 1);
    check({name, "_mismatch"}, mismatch, 0);
    check({name, "_timeout"}, timeout, 0);
    check({name, "_out_cnt"}, out_cnt, N);
    check({name, "_ila_stream"}, seq_ok(ila_seen), 1);
    check({name, "_hls_stream"}, seq_ok(hls_seen), 1);
    check({name, "_ens_off"}, {ila_en, hls_en}, 2'b00);
    $display("run %s: done=%0b mismatch=%0b out_cnt=%0d", name, done, mismatch, out_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int prev;
    rst = 1'b1; start = 1'b0; src_tvalid = 1'b0; src_tdata = '0;
    ila_in_tready = 1'b0; hls_in_tready = 1'b0;
    ila_out_tvalid = 1'b0; ila_out_tdata = '0; hls_out_tvalid = 1'b0; hls_out_tdata = '0;
    src_idx = 0; ila_recv = 0; hls_recv = 0; hls_block = 0; hls_mode = 0;
    corrupt_idx = -1; cyc = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    src_tvalid = 1'b1; ila_in_tready = 1'b1; hls_in_tready = 1'b1; ila_out_tvalid = 1'b1;
    #1;
    check("rst_dut_rst", dut_rst, 1);
    check("rst_flags", {done, mismatch, timeout}, 3'b000);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_mm_index", mm_index, 0);
    check("rst_ens", {ila_en, hls_en}, 2'b00);
    check("rst_src_tready", src_tready, 0);
    check("rst_in_tvalid", {ila_in_tvalid, hls_in_tvalid}, 2'b00);
    check("rst_out_tready", {ila_out_tready, hls_out_tready}, 2'b00);
    $display("reset: dut_rst=%0b out_cnt=%0d", dut_rst, out_cnt);
    @(negedge clk);

    // Identical designs, random handshakes.
    start_run("basic");
    run_to_end("basic");
    check_good_run("basic");

    // HLS input stalled for 5 cycles while ILA is ready.
    start_run("stall");
    hls_block = 5;
    repeat (5) cycle();
    check("stall_ila_took_once", ila_seen.size(), 1);
    check("stall_hls_took_none", hls_seen.size(), 0);
    run_to_end("stall");
    check_good_run("stall");

    // Slow HLS output: ILA reaches its last output first.
    hls_mode = 2;
    start_run("early");
    n = 0;
    while (!(done || mismatch || timeout) && n < 400) begin
      prev = ila_recv;
      cycle(); n++;
      if (prev < N && ila_recv == N) begin
        check("early_ila_en_off", ila_en, 0);
        check("early_hls_en", hls_en, (hls_recv < N) ? 1 : 0);
        $display("early: ila finished, hls_recv=%0d hls_en=%0b", hls_recv, hls_en);
      end
    end
    check_good_run("early");
    hls_mode = 0;

    // Corrupted HLS output at index 3 (0x5A vs ILA 0x5B).
    corrupt_idx = 3;
    start_run("corrupt");
    run_to_end("corrupt");
    check("corrupt_mismatch", mismatch, 1);
    check("corrupt_mm_index", mm_index, exp_mm(corrupt_idx));
    cycle(); cycle();
    check("corrupt_ens_off", {ila_en, hls_en}, 2'b00);
    check("corrupt_done", done, 0);
    check("corrupt_still_flagged", mismatch, 1);
    $display("corrupt: mismatch=%0b mm_index=%0d", mismatch, mm_index);
    corrupt_idx = -1;

    // HLS output stuck low: timeout after MAXC RUN cycles.
    hls_mode = 1;
    start_run("timeout");
    n = 0;
    while (!timeout && n < 200) begin
      n++;
      if (n == 40) check("timeout_ila_fifo_full_tready", ila_out_tready, 0);
      cycle();
    end
    check("timeout_run_cycles", n, MAXC);
    check("timeout_flag", timeout, 1);
    check("timeout_done", done, 0);
    check("timeout_ila_buffered", ila_recv, DEPTH);
    $display("timeout: after %0d run cycles, ila_recv=%0d", n, ila_recv);

    // Reset in RUN with two ILA outputs buffered.
    start_run("midrst");
    n = 0;
    while (ila_recv < 2 && n < 100) begin cycle(); n++; end
    check("midrst_buffered", ila_recv, 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_dut_rst", dut_rst, 1);
    check("midrst_flags", {done, mismatch, timeout}, 3'b000);
    check("midrst_out_cnt", out_cnt, 0);
    check("midrst_ens", {ila_en, hls_en}, 2'b00);
    check("midrst_out_tready", ila_out_tready, 0);
    $display("midrst: dut_rst=%0b", dut_rst);
    hls_mode = 0;
    start_run("after_rst");
    run_to_end("after_rst");
    check_good_run("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
